// File: rtl/pdu_pkg.sv
// Shared types and defaults for the PDU run/step/breakpoint controller.
package pdu_pkg;

  localparam int NSTEP_W_DEF = 8;
  localparam int CNT_W_DEF   = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_STEP = 2'b01,
    S_RUN  = 2'b10,
    S_BRK  = 2'b11
  } pdu_state_e;

endpackage

// File: rtl/pdu_sync_edge.sv
// Two-flop synchronizer for a raw switch/button, with a one-cycle rising-edge pulse.
module pdu_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      prev_q <= sync_q[1];
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~prev_q;

endmodule

// File: rtl/pdu_run_ctrl.sv
// Run/step/breakpoint controller producing a registered CPU clock enable and a cycle counter.
// Define PDU_BRK_EN to build the PC breakpoint comparator and the BRK state.
//
//   state  | meaning
//   IDLE   | CPU halted, waiting for run level or step press
//   STEP   | issuing a burst of `remaining` enables
//   RUN    | free running, one enable per cycle
//   BRK    | halted on PC breakpoint until run drops or step pressed
module pdu_run_ctrl
  import pdu_pkg::*;
#(
  parameter int NSTEP_W = NSTEP_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               run_i,
  input  logic               step_i,
  input  logic [NSTEP_W-1:0] nstep_i,
  input  logic               brk_en_i,
  input  logic [31:0]        brk_addr_i,
  input  logic [31:0]        pc_i,
  input  logic               clr_cnt_i,
  output logic               cpu_ce_o,
  output logic [1:0]         state_o,
  output logic               halted_o,
  output logic [CNT_W-1:0]   cyc_cnt_o
);

  localparam logic [NSTEP_W-1:0] STEP_ONE = NSTEP_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  logic run_r;
  logic step_p;
  logic run_rise_unused;

  pdu_sync_edge u_sync_run (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .d_i     (run_i),
    .level_o (run_r),
    .rise_o  (run_rise_unused)
  );

  logic step_level_unused;

  pdu_sync_edge u_sync_step (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .d_i     (step_i),
    .level_o (step_level_unused),
    .rise_o  (step_p)
  );

  pdu_state_e         state_q, state_d;
  logic [NSTEP_W-1:0] remaining_q, remaining_d;
  logic               skip_q, skip_d;
  logic               ce_q, ce_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NSTEP_W-1:0] nstep_eff;
  logic               hit;
  logic               ce_out;

  assign nstep_eff = (nstep_i == '0) ? STEP_ONE : nstep_i;

`ifdef PDU_BRK_EN
  assign hit = (state_q == S_RUN) & brk_en_i & (pc_i == brk_addr_i) & ~skip_q;
`else
  logic unused_brk;
  assign hit        = 1'b0;
  assign unused_brk = ^{brk_en_i, brk_addr_i, pc_i, skip_q};
`endif

  // A hit suppresses the already-registered enable so the CPU never fetches past brk_addr.
  assign ce_out = ce_q & ~hit;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    skip_d      = skip_q;
    ce_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_r) begin
          state_d = S_RUN;
          skip_d  = 1'b1;
          ce_d    = 1'b1;
        end else if (step_p) begin
          state_d     = S_STEP;
          remaining_d = nstep_eff;
        end
      end
      S_STEP: begin
        ce_d        = 1'b1;
        remaining_d = remaining_q - STEP_ONE;
        if (run_r) begin
          state_d     = S_RUN;
          skip_d      = 1'b1;
          remaining_d = '0;
        end else if (remaining_q <= STEP_ONE) begin
          state_d     = S_IDLE;
          remaining_d = '0;
        end
      end
      S_RUN: begin
        if (ce_out) skip_d = 1'b0;
        if (!run_r) begin
          state_d = S_IDLE;
        end else if (hit) begin
          state_d = S_BRK;
        end else begin
          ce_d = 1'b1;
        end
      end
      S_BRK: begin
        if (step_p) begin
          state_d     = S_STEP;
          remaining_d = nstep_eff;
        end else if (!run_r) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign halted_d = (state_d == S_IDLE) || (state_d == S_BRK);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt_i)   cnt_d = '0;
    else if (ce_out) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      skip_q      <= 1'b0;
      ce_q        <= 1'b0;
      halted_q    <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      skip_q      <= skip_d;
      ce_q        <= ce_d;
      halted_q    <= halted_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cpu_ce_o  = ce_out;
  assign state_o   = state_q;
  assign halted_o  = halted_q;
  assign cyc_cnt_o = cnt_q;

endmodule
